// File: rtl/hazard_scoreboard.sv
// Five-stage MIPS hazard unit: a shift-register scoreboard of in-flight writes drives stall and forward selects.
// Define HAZARD_STATS_EN to add the stall_cnt / md_stall_cnt performance counters.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int TNEW_W     = 2,
  parameter int NUM_STAGES = 3,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [REG_AW-1:0]                     d_rs,
  input  logic [REG_AW-1:0]                     d_rt,
  input  logic                                  d_rs_used,
  input  logic                                  d_rt_used,
  input  logic [TNEW_W-1:0]                     d_tuse_rs,
  input  logic [TNEW_W-1:0]                     d_tuse_rt,
  input  logic [REG_AW-1:0]                     d_a3,
  input  logic [TNEW_W-1:0]                     d_tnew,
  input  logic                                  d_is_md,
  input  logic                                  md_start,
  input  logic                                  md_is_div,
  input  logic                                  flush,
  output logic                                  stall,
  output logic [$clog2(NUM_STAGES+1)-1:0]       d_fwd_rs_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]       d_fwd_rt_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]       e_fwd_rs_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]       e_fwd_rt_sel,
  output logic                                  md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                           stall_cnt,
  output logic [31:0]                           md_stall_cnt
`endif
);

  localparam int SEL_W  = $clog2(NUM_STAGES + 1);
  localparam int MD_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [TNEW_W-1:0] tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
  } entry_t;

  // Index k is the stage k positions downstream of D (1 = E, 2 = M, ...).
  entry_t          entry_q [1:NUM_STAGES];
  entry_t          d_entry;
  logic [MD_W-1:0] md_cnt_q;
  logic            reg_hazard;
  logic            md_lock;

  function automatic entry_t age(input entry_t e);
    entry_t r;
    r = e;
    if (e.tnew != '0) r.tnew = e.tnew - TNEW_W'(1);
    return r;
  endfunction

  always_comb begin
    d_entry         = '0;
    d_entry.a3      = d_a3;
    d_entry.tnew    = d_tnew;
    d_entry.rs      = d_rs;
    d_entry.rt      = d_rt;
    d_entry.rs_used = d_rs_used;
    d_entry.rt_used = d_rt_used;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  // NOTE: every entry is reset; the array is only NUM_STAGES deep and a stale
  // a3/tnew after reset would raise phantom stalls, unlike a datapath RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= NUM_STAGES; k++) entry_q[k] <= '0;
    end else if (flush) begin
      for (int k = 1; k <= NUM_STAGES; k++) entry_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every entry
      // shifts from its pre-edge neighbour regardless of statement order.
      entry_q[1] <= stall ? entry_t'('0) : d_entry;
      for (int k = 2; k <= NUM_STAGES; k++) entry_q[k] <= age(entry_q[k-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide busy counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q <= '0;
    end else if (md_start && md_cnt_q == '0) begin
      md_cnt_q <= md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_q <= md_cnt_q - MD_W'(1);
    end
  end

  assign md_busy = (md_cnt_q != '0);
  assign md_lock = d_is_md && (md_start || md_busy);

  // ---------------------------------------------------------------------------
  // Register hazards: source needed before the in-flight producer delivers it
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every combinationally assigned signal first; a path that
    // skips the assignment would otherwise infer a latch.
    reg_hazard = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (entry_q[k].a3 != '0 && d_rs_used && d_rs == entry_q[k].a3 &&
          d_tuse_rs < entry_q[k].tnew)
        reg_hazard = 1'b1;
      if (entry_q[k].a3 != '0 && d_rt_used && d_rt == entry_q[k].a3 &&
          d_tuse_rt < entry_q[k].tnew)
        reg_hazard = 1'b1;
    end
  end

  // The md_start term is a raw input, so gate with reset to keep stall low in reset.
  assign stall = reset_n && (reg_hazard || md_lock);

  // ---------------------------------------------------------------------------
  // Forward selects: scan far to near so the nearest ready producer wins
  // ---------------------------------------------------------------------------
  always_comb begin
    d_fwd_rs_sel = '0;
    d_fwd_rt_sel = '0;
    e_fwd_rs_sel = '0;
    e_fwd_rt_sel = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (entry_q[k].a3 != '0 && entry_q[k].tnew == '0) begin
        if (entry_q[k].a3 == d_rs) d_fwd_rs_sel = SEL_W'(k);
        if (entry_q[k].a3 == d_rt) d_fwd_rt_sel = SEL_W'(k);
      end
    end
    for (int k = NUM_STAGES; k >= 2; k--) begin
      if (entry_q[k].a3 != '0 && entry_q[k].tnew == '0) begin
        if (entry_q[1].rs_used && entry_q[1].rs == entry_q[k].a3)
          e_fwd_rs_sel = SEL_W'(k);
        if (entry_q[1].rt_used && entry_q[1].rt == entry_q[k].a3)
          e_fwd_rt_sel = SEL_W'(k);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Free-running statistics; flush leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (stall && !reg_hazard) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expectations are queued with the stimulus
// and popped by a negedge scoreboard; reset behaviour is checked inline.
module tb_hazard_scoreboard;

  localparam int SEL_W = 2;

  logic             clk;
  logic             reset_n;
  logic [4:0]       d_rs, d_rt, d_a3;
  logic             d_rs_used, d_rt_used;
  logic [1:0]       d_tuse_rs, d_tuse_rt, d_tnew;
  logic             d_is_md, md_start, md_is_div, flush;
  logic             stall;
  logic [SEL_W-1:0] d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel;
  logic             md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cnt, md_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // -1 in any field means "don't care" for that cycle.
  typedef struct {
    string name;
    int    stall;
    int    drs;
    int    drt;
    int    ers;
    int    ert;
    int    busy;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_rs_used    (d_rs_used),
    .d_rt_used    (d_rt_used),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_a3         (d_a3),
    .d_tnew       (d_tnew),
    .d_is_md      (d_is_md),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .flush        (flush),
    .stall        (stall),
    .d_fwd_rs_sel (d_fwd_rs_sel),
    .d_fwd_rt_sel (d_fwd_rt_sel),
    .e_fwd_rs_sel (e_fwd_rs_sel),
    .e_fwd_rt_sel (e_fwd_rt_sel),
    .md_busy      (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare the DUT against the expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.stall >= 0) begin
        checks++;
        if (stall !== 1'(e.stall)) begin
          failures++;
          $display("FAIL %s stall: got %0b required %0d", e.name, stall, e.stall);
        end
      end
      if (e.drs >= 0) begin
        checks++;
        if (d_fwd_rs_sel !== SEL_W'(e.drs)) begin
          failures++;
          $display("FAIL %s d_fwd_rs_sel: got %0d required %0d", e.name, d_fwd_rs_sel, e.drs);
        end
      end
      if (e.drt >= 0) begin
        checks++;
        if (d_fwd_rt_sel !== SEL_W'(e.drt)) begin
          failures++;
          $display("FAIL %s d_fwd_rt_sel: got %0d required %0d", e.name, d_fwd_rt_sel, e.drt);
        end
      end
      if (e.ers >= 0) begin
        checks++;
        if (e_fwd_rs_sel !== SEL_W'(e.ers)) begin
          failures++;
          $display("FAIL %s e_fwd_rs_sel: got %0d required %0d", e.name, e_fwd_rs_sel, e.ers);
        end
      end
      if (e.ert >= 0) begin
        checks++;
        if (e_fwd_rt_sel !== SEL_W'(e.ert)) begin
          failures++;
          $display("FAIL %s e_fwd_rt_sel: got %0d required %0d", e.name, e_fwd_rt_sel, e.ert);
        end
      end
      if (e.busy >= 0) begin
        checks++;
        if (md_busy !== 1'(e.busy)) begin
          failures++;
          $display("FAIL %s md_busy: got %0b required %0d", e.name, md_busy, e.busy);
        end
      end
    end
  end

  task automatic push(input string name, input int st, input int drs, input int drt,
                      input int ers, input int ert, input int busy);
    exp_t e;
    e.name  = name;
    e.stall = st;
    e.drs   = drs;
    e.drt   = drt;
    e.ers   = ers;
    e.ert   = ert;
    e.busy  = busy;
    exp_q.push_back(e);
  endtask

  task automatic set_d(input int rs, input int rt, input bit rs_u, input bit rt_u,
                       input int tu_rs, input int tu_rt, input int a3, input int tnew,
                       input bit is_md);
    d_rs      = 5'(rs);
    d_rt      = 5'(rt);
    d_rs_used = rs_u;
    d_rt_used = rt_u;
    d_tuse_rs = 2'(tu_rs);
    d_tuse_rt = 2'(tu_rt);
    d_a3      = 5'(a3);
    d_tnew    = 2'(tnew);
    d_is_md   = is_md;
  endtask

  task automatic set_idle;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one cycle; the scoreboard samples on the negedge in between.
  task automatic tick;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    set_idle();
    md_start  = 1'b0;
    md_is_div = 1'b0;
    flush     = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    set_idle();
    flush     = 1'b0;
    md_start  = 1'b1;
    md_is_div = 1'b1;
    d_is_md   = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %0b required 0", stall);
    end
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_md_busy: got %0b required 0", md_busy);
    end
    checks++;
    if ({d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel} !== 8'h00) begin
      failures++;
      $display("FAIL reset_sels: got %h required 00",
               {d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel});
    end
    @(posedge clk);
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_md_hold: got %0b required 0", md_busy);
    end
    md_start  = 1'b0;
    md_is_div = 1'b0;
    d_is_md   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use;
    drain();
    set_d(0, 0, 0, 0, 0, 0, 8, 2, 0);              // lw $8
    push("lw_issue", 0, 0, 0, 0, 0, 0);
    tick();
    set_d(8, 0, 1, 1, 0, 0, 0, 0, 0);              // beq $8,$0
    push("beq_stall1", 1, 0, 0, 0, 0, 0);
    tick();
    push("beq_stall2", 1, 0, 0, 0, 0, 0);
    tick();
    push("beq_fwd_w", 0, 3, 0, 0, 0, 0);
    tick();
    set_idle();
    push("beq_in_e", 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_alu_forward;
    drain();
    set_d(1, 2, 1, 1, 1, 1, 9, 1, 0);              // addu $9,$1,$2
    push("addu9_issue", 0, 0, 0, 0, 0, 0);
    tick();
    set_d(9, 3, 1, 1, 1, 1, 10, 1, 0);             // addu $10,$9,$3
    push("addu10_no_stall", 0, 0, 0, 0, 0, 0);
    tick();
    set_idle();
    push("addu10_e_fwd_m", 0, 0, 0, 2, 0, 0);
    tick();
    set_d(9, 10, 1, 1, 0, 0, 0, 0, 0);             // beq $9,$10
    push("beq_d_fwd_mw", 0, 3, 2, 0, 0, 0);
    tick();
    set_idle();
    push("beq_e_fwd_w", 0, 0, 0, 0, 3, 0);
    tick();
  endtask

  task automatic test_nearest;
    drain();
    set_d(0, 0, 0, 0, 0, 0, 5, 0, 0);
    push("w5_first", 0, 0, 0, 0, 0, 0);
    tick();
    push("w5_second", 0, 0, 0, 0, 0, 0);
    tick();
    set_d(5, 5, 1, 1, 0, 0, 0, 0, 0);
    push("nearest_d", 0, 1, 1, 0, 0, 0);
    tick();
    set_idle();
    push("nearest_e", 0, 0, 0, 2, 2, 0);
    tick();
  endtask

  task automatic test_reg_zero;
    drain();
    set_d(0, 0, 0, 0, 0, 0, 0, 2, 0);              // write to $0, tnew=2
    push("r0_issue", 0, 0, 0, 0, 0, 0);
    tick();
    set_d(0, 0, 1, 1, 0, 0, 0, 0, 0);
    push("r0_no_hazard1", 0, 0, 0, 0, 0, 0);
    tick();
    push("r0_no_hazard2", 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_md;
    drain();
    set_d(0, 0, 0, 0, 0, 0, 12, 1, 1);             // mflo $12
    md_start  = 1'b1;
    md_is_div = 1'b1;
    push("div_start", 1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      md_start  = (i == 3);                        // issue while busy must be ignored
      md_is_div = 1'b0;
      push($sformatf("div_busy_%0d", i), 1, 0, 0, 0, 0, 1);
      tick();
    end
    md_start = 1'b0;
    push("div_done", 0, 0, 0, 0, 0, 0);
    tick();
    set_idle();
    md_start  = 1'b1;
    md_is_div = 1'b0;
    push("mul_start", 0, 0, 0, 0, 0, 0);
    tick();
    md_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push($sformatf("mul_busy_%0d", i), 0, 0, 0, 0, 0, 1);
      tick();
    end
    push("mul_done", 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush_and_async_reset;
    drain();
    set_d(0, 0, 0, 0, 0, 0, 8, 2, 0);              // lw $8
    push("fl_lw", 0, 0, 0, 0, 0, 0);
    tick();
    set_d(8, 0, 1, 0, 0, 0, 0, 0, 0);              // beq $8 with flush
    flush = 1'b1;
    push("fl_stall_flush", 1, 0, 0, 0, 0, 0);
    tick();
    flush = 1'b0;
    push("fl_after", 0, 0, 0, 0, 0, 0);
    tick();
    set_idle();
    md_start  = 1'b1;
    md_is_div = 1'b1;
    push("fl_div_start", 0, 0, 0, 0, 0, 0);
    tick();
    md_start = 1'b0;
    d_is_md  = 1'b1;
    flush    = 1'b1;
    push("fl_md_flush", 1, 0, 0, 0, 0, 1);
    tick();
    flush = 1'b0;
    push("fl_md_keeps", 1, 0, 0, 0, 0, 1);
    tick();

    reset_n = 1'b0;                                // mid-divide, away from the edge
    #1;
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_md_busy: got %0b required 0", md_busy);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_stall: got %0b required 0", stall);
    end
    @(negedge clk);
    reset_n = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 8, 2, 0);              // captured on the first edge after release
    @(posedge clk);
    #1;
    set_d(8, 0, 1, 0, 0, 0, 0, 0, 0);
    push("post_reset_capture", 1, 0, 0, 0, 0, 0);
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_forward();
    test_nearest();
    test_reg_zero();
    test_md();
    test_flush_and_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the five-stage MIPS pipeline. It replaces purely combinational per-instruction decode with an internal shift-register scoreboard of in-flight destination registers and their remaining Tnew.
- Produces the D-stage stall, D-stage and E-stage forward selects, and multiply/divide busy interlock.
- Sits beside the pipeline registers and is fed by the D-stage decoder.

Parameters:
- REG_AW, 5, register address width.
- TNEW_W, 2, width of Tuse/Tnew fields.
- NUM_STAGES, 3, tracked stages downstream of D (index 1=E, 2=M, 3=W); minimum 2.
- MUL_CYCLES, 5, mult/multu busy cycles.
- DIV_CYCLES, 10, div/divu busy cycles.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active low.
- d_rs, d_rt  in  REG_AW  D-stage source register numbers.
- d_rs_used, d_rt_used  in  1  source actually read.
- d_tuse_rs, d_tuse_rt  in  TNEW_W  Tuse of each source.
- d_a3  in  REG_AW  D-stage destination; 0 = no write.
- d_tnew  in  TNEW_W  Tnew of the D instruction as seen on entering E.
- d_is_md  in  1  D instruction uses HI/LO or the md unit.
- md_start  in  1  E-stage mult/div issue pulse.
- md_is_div  in  1  qualifies md_start.
- flush  in  1  synchronous clear of all scoreboard entries.
- stall  out  1  freeze PC/D, bubble into E.
- d_fwd_rs_sel, d_fwd_rt_sel  out  $clog2(NUM_STAGES+1)  0 = regfile, k = stage k.
- e_fwd_rs_sel, e_fwd_rt_sel  out  same  0 = none, k = stage k (k≥2).
- md_busy  out  1  md counter non-zero.

Behaviour:
- Entry k holds {a3, tnew, rs, rt, rs_used, rt_used}. All entries reset to 0 (bubble); md counter resets to 0. stall, selects and md_busy are 0 in reset.
- Each clk edge:
  - Entry k+1 ← entry k with tnew saturating-decremented (0 stays 0).
  - Entry 1 ← D fields if !stall, else bubble (all zero).
  - Last entry retires.
- flush: all entries become bubble on that edge, overriding the stall and D capture. The md counter is unaffected.
- Hazard on entry k (combinational):
  - a3 ≠ 0 and rs_used and d_rs == a3 and d_tuse_rs < tnew(k); same for rt.
- stall = OR over all k of both hazards, OR md interlock. Zero-cycle latency: same cycle as the D inputs.
- D forwarding: smallest k with a3 == src, a3 ≠ 0, tnew(k) == 0. Nearest stage wins. 0 if none.
- E forwarding: compare entry-1 rs/rt (when used) against entries k ≥ 2 with tnew == 0, smallest k wins. 0 if none.
- md counter:
  - On md_start with counter == 0, load DIV_CYCLES if md_is_div, else MUL_CYCLES.
  - Decrement each cycle while non-zero.
  - md_start while busy is ignored.
- md interlock: d_is_md and (md_start or md_busy).
- Register 0 never produces a hazard or forward.
- Reset mid-operation clears everything asynchronously. The first edge after release captures normally.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds output stall_cnt [31:0], counting cycles with stall = 1 (wrap-around at 2^32).
  - Adds output md_stall_cnt [31:0], counting cycles where only the md interlock caused the stall.
  - Both reset to 0; flush does not clear them.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- lw $8 (d_a3=8, d_tnew=2), then beq using $8 (tuse_rs=0) → stall=1 for 2 cycles. Then d_fwd_rs_sel=3 (W), no further stall.
- addu $9 (tnew=1), then addu reading $9 (tuse=1) → no stall. E-stage e_fwd_rs_sel=2 one cycle later.
- Same destination $5 in stages 1 and 2, both tnew=0 → d_fwd_rs_sel=1 (nearest).
- d_rs=0 while an in-flight a3=0 write has tnew=2 → stall=0, sel=0.
- md_start with md_is_div=1, then mflo in D (d_is_md=1) → stall=1 for 11 cycles (start cycle + 10 busy). md_busy falls exactly 10 cycles after start. A second md_start mid-busy is ignored.
- Stall asserted and flush pulsed same cycle → all entries bubble next cycle, stall=0 unless md interlock. Async reset_n low mid-divide → md_busy=0 immediately.
